// File: rtl/stm32_bus_master.sv
// Initiator end of the 4-bit STM32 <-> DDC nibble link; one command per frame, all outputs registered.
// Optional build macro OTR_STICKY_EN adds a sticky overrange flag (otr_sticky) and its clear (otr_clr).
module stm32_bus_master #(
   parameter int GAP_CYCLES = 1,
   parameter int RD_LAT     = 1
) (
   input  logic               clk_in,
   input  logic               reset_in,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [21:0]        cmd_freq,
   input  logic               cmd_preamp,
   input  logic               cmd_tx,
   input  logic signed [15:0] cmd_tx_i,
   input  logic signed [15:0] cmd_tx_q,
   output logic               bus_sync,
   output logic [3:0]         bus_data_out,
   input  logic [3:0]         bus_data_in,
   output logic               rsp_valid,
   output logic [1:0]         rsp_op,
   output logic signed [15:0] rsp_i,
   output logic signed [15:0] rsp_q,
   output logic               rsp_otr,
`ifdef OTR_STICKY_EN
   input  logic               otr_clr,
   output logic               otr_sticky,
`endif
   output logic               busy
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SYNC = 3'd1;
   localparam logic [2:0] S_SEND = 3'd2;
   localparam logic [2:0] S_RECV = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_GAP  = 3'd5;

   localparam logic [1:0] OP_SET  = 2'd0;
   localparam logic [1:0] OP_STAT = 2'd1;
   localparam logic [1:0] OP_TXIQ = 2'd2;

   localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

   logic [2:0]         state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               sync_q, sync_d;
   logic [3:0]         data_q, data_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [1:0]         rsp_op_q, rsp_op_d;
   logic signed [15:0] rsp_i_q, rsp_i_d;
   logic signed [15:0] rsp_q_q, rsp_q_d;
   logic               rsp_otr_q, rsp_otr_d;
   logic [31:0]        sh_q, sh_d;
   logic [27:0]        rx_q, rx_d;
   logic [1:0]         op_q, op_d;
   logic [3:0]         nib_len;
   logic [31:0]        rx_shift;
`ifdef OTR_STICKY_EN
   logic               sticky_q, sticky_d;
`endif

   assign rx_shift = {rx_q, bus_data_in};

   always_comb begin
      case (op_q)
         OP_SET:  nib_len = 4'd7;
         OP_STAT: nib_len = 4'd1;
         default: nib_len = 4'd8;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ready_d     = ready_q;
      busy_d      = busy_q;
      sync_d      = 1'b0;
      data_d      = 4'h0;
      rsp_valid_d = 1'b0;
      rsp_op_d    = rsp_op_q;
      rsp_i_d     = rsp_i_q;
      rsp_q_d     = rsp_q_q;
      rsp_otr_d   = rsp_otr_q;
      sh_d        = sh_q;
      rx_d        = rx_q;
      op_d        = op_q;
`ifdef OTR_STICKY_EN
      sticky_d    = otr_clr ? 1'b0 : sticky_q;
`endif
      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (cmd_valid && ready_q) begin
               state_d = S_SYNC;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               sync_d  = 1'b1;
               data_d  = {2'b00, cmd_op} + 4'd1;
               op_d    = cmd_op;
               cnt_d   = 4'd0;
               // Payload is left-aligned so SEND always emits sh_q[31:28] and shifts.
               case (cmd_op)
                  OP_SET:  sh_d = {cmd_tx, cmd_preamp, 2'b00, 2'b00, cmd_freq, 4'h0};
                  OP_TXIQ: sh_d = {cmd_tx_q, cmd_tx_i};
                  default: sh_d = 32'h0;
               endcase
            end
         end
         S_SYNC: begin
            if (!op_q[0]) begin
               state_d = S_SEND;
               data_d  = sh_q[31:28];
               sh_d    = {sh_q[27:0], 4'h0};
               cnt_d   = 4'd1;
            end else begin
               state_d = S_RECV;
               cnt_d   = 4'd0;
            end
         end
         S_SEND: begin
            if (cnt_q == nib_len) begin
               state_d     = S_DONE;
               rsp_valid_d = 1'b1;
               rsp_op_d    = op_q;
            end else begin
               data_d = sh_q[31:28];
               sh_d   = {sh_q[27:0], 4'h0};
               cnt_d  = cnt_q + 4'd1;
            end
         end
         S_RECV: begin
            // The first RD_LAT edges after SYNC carry no data from the slave yet.
            if (cnt_q >= RD_LAT_C) begin
               rx_d = rx_shift[27:0];
               if (cnt_q - RD_LAT_C == nib_len - 4'd1) begin
                  state_d     = S_DONE;
                  rsp_valid_d = 1'b1;
                  rsp_op_d    = op_q;
                  if (op_q == OP_STAT) begin
                     rsp_otr_d = bus_data_in[0];
`ifdef OTR_STICKY_EN
                     if (bus_data_in[0]) sticky_d = 1'b1;
`endif
                  end else begin
                     rsp_q_d = rx_shift[31:16];
                     rsp_i_d = rx_shift[15:0];
                  end
               end
            end
            cnt_d = cnt_q + 4'd1;
         end
         S_DONE: begin
            state_d = S_GAP;
            cnt_d   = 4'd0;
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         sync_q      <= 1'b0;
         data_q      <= 4'h0;
         rsp_valid_q <= 1'b0;
         rsp_op_q    <= 2'd0;
         rsp_i_q     <= '0;
         rsp_q_q     <= '0;
         rsp_otr_q   <= 1'b0;
`ifdef OTR_STICKY_EN
         sticky_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         sync_q      <= sync_d;
         data_q      <= data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_op_q    <= rsp_op_d;
         rsp_i_q     <= rsp_i_d;
         rsp_q_q     <= rsp_q_d;
         rsp_otr_q   <= rsp_otr_d;
`ifdef OTR_STICKY_EN
         sticky_q    <= sticky_d;
`endif
      end
   end

   // Frame payload/capture registers carry no control meaning, so they skip reset.
   always_ff @(posedge clk_in) begin
      sh_q <= sh_d;
      rx_q <= rx_d;
      op_q <= op_d;
   end

   assign cmd_ready    = ready_q;
   assign busy         = busy_q;
   assign bus_sync     = sync_q;
   assign bus_data_out = data_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_op       = rsp_op_q;
   assign rsp_i        = rsp_i_q;
   assign rsp_q        = rsp_q_q;
   assign rsp_otr      = rsp_otr_q;
`ifdef OTR_STICKY_EN
   assign otr_sticky   = sticky_q;
`endif

endmodule

// File: tb/tb_stm32_bus_master.sv
// Self-checking bench for stm32_bus_master: vector table per frame, response scoreboard, slave model.
module tb_stm32_bus_master;
   localparam int GAP_P = 1;
   localparam int RDL_P = 1;
   localparam logic [3:0] IDLE_NIB = 4'h6;

   logic               clk_in = 1'b0;
   logic               reset_in;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [21:0]        cmd_freq;
   logic               cmd_preamp;
   logic               cmd_tx;
   logic signed [15:0] cmd_tx_i;
   logic signed [15:0] cmd_tx_q;
   logic               bus_sync;
   logic [3:0]         bus_data_out;
   logic [3:0]         bus_data_in;
   logic               rsp_valid;
   logic [1:0]         rsp_op;
   logic signed [15:0] rsp_i;
   logic signed [15:0] rsp_q;
   logic               rsp_otr;
   logic               busy;
`ifdef OTR_STICKY_EN
   logic               otr_clr;
   logic               otr_sticky;
   logic               m_stk;
`endif

   always #5 clk_in = ~clk_in;

   stm32_bus_master #(.GAP_CYCLES(GAP_P), .RD_LAT(RDL_P)) dut (
      .clk_in(clk_in), .reset_in(reset_in),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_freq(cmd_freq), .cmd_preamp(cmd_preamp), .cmd_tx(cmd_tx),
      .cmd_tx_i(cmd_tx_i), .cmd_tx_q(cmd_tx_q),
      .bus_sync(bus_sync), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
      .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_i(rsp_i), .rsp_q(rsp_q),
      .rsp_otr(rsp_otr),
`ifdef OTR_STICKY_EN
      .otr_clr(otr_clr), .otr_sticky(otr_sticky),
`endif
      .busy(busy)
   );

   typedef struct {
      logic [1:0]  op;
      logic [21:0] freq;
      logic        preamp;
      logic        tx;
      logic [15:0] ti;
      logic [15:0] tq;
      logic [31:0] ret;
      logic [3:0]  code;
      logic [31:0] pay;
      int          nl;
      int          frame;
      logic [15:0] eq;
      logic [15:0] ei;
      logic        eotr;
   } vec_t;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] q;
      logic [15:0] i;
      logic        otr;
   } sb_t;

   vec_t        tbl [10];
   sb_t         sbq [$];
   sb_t         sb_e;
   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] slv_word = 32'h0;
   logic [15:0] m_q = 16'h0, m_i = 16'h0;
   logic        m_otr = 1'b0;
   int          sync_t [3];
   int          n_sync;

   function automatic vec_t mk(input logic [1:0] op, input logic [21:0] fr, input logic pa,
                               input logic tx, input logic [15:0] ti, input logic [15:0] tq,
                               input logic [31:0] ret, input logic [3:0] code,
                               input logic [31:0] pay, input int nl, input int fl,
                               input logic [15:0] eq, input logic [15:0] ei, input logic eo);
      vec_t v;
      v.op = op; v.freq = fr; v.preamp = pa; v.tx = tx; v.ti = ti; v.tq = tq;
      v.ret = ret; v.code = code; v.pay = pay; v.nl = nl; v.frame = fl;
      v.eq = eq; v.ei = ei; v.eotr = eo;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic wait_ready();
      int t = 0;
      @(negedge clk_in);
      while (cmd_ready !== 1'b1 && t < 100) begin
         @(negedge clk_in);
         t++;
      end
      if (t >= 100) begin
         n_chk++;
         n_err++;
         $display("FAIL wait_ready: cmd_ready still %b after %0d cycles, required 1", cmd_ready, t);
      end
   endtask

   // Drives one command and checks every cycle of its frame; abort_k>0 asserts reset after that cycle.
   task automatic run_vec(input vec_t v, input int idx, input int abort_k);
      int          fl, done_k;
      logic        s_e;
      logic [3:0]  d_e;
      logic [40:0] a_v, e_v;
      fl     = v.frame + GAP_P - 1 + (v.op[0] ? RDL_P - 1 : 0);
      done_k = fl - 1 - GAP_P;
      wait_ready();
      slv_word   = v.ret;
      cmd_valid  = 1'b1;
      cmd_op     = v.op;
      cmd_freq   = v.freq;
      cmd_preamp = v.preamp;
      cmd_tx     = v.tx;
      cmd_tx_i   = v.ti;
      cmd_tx_q   = v.tq;
      if (abort_k == 0) sbq.push_back('{v.op, v.eq, v.ei, v.eotr});
      @(posedge clk_in);
      @(negedge clk_in);
      cmd_valid  = 1'b0;
      cmd_op     = 2'($urandom);
      cmd_freq   = 22'($urandom);
      cmd_preamp = 1'($urandom);
      cmd_tx     = 1'($urandom);
      cmd_tx_i   = 16'($urandom);
      cmd_tx_q   = 16'($urandom);
      for (int k = 1; k <= fl; k++) begin
         if (k > 1) @(negedge clk_in);
         s_e = (k == 1);
         d_e = 4'h0;
         if (k == 1) d_e = v.code;
         else if (k <= 1 + v.nl) d_e = v.pay[31 - 4*(k-2) -: 4];
         if (k == done_k) begin
            if (v.op == 2'd3) begin
               m_q = v.eq;
               m_i = v.ei;
            end else if (v.op == 2'd1) begin
               m_otr = v.eotr;
            end
         end
         e_v = {s_e, d_e, (k == done_k), (k == fl), (k != fl), m_q, m_i, m_otr};
         a_v = {bus_sync, bus_data_out, rsp_valid, cmd_ready, busy, rsp_q, rsp_i, rsp_otr};
         chk($sformatf("vec%0d_cyc%0d", idx, k), 64'(a_v), 64'(e_v));
`ifdef OTR_STICKY_EN
         if (k == done_k && v.op == 2'd1 && v.eotr) m_stk = 1'b1;
         else if (otr_clr) m_stk = 1'b0;
         chk($sformatf("vec%0d_sticky%0d", idx, k), 64'(otr_sticky), 64'(m_stk));
`endif
         if (k == abort_k) begin
            reset_in = 1'b1;
            return;
         end
      end
   endtask

   // Slave: answers GET_STATUS/RX_IQ frames, nibble n valid at edge E0+1+RD_LAT+n.
   initial begin
      int cnt;
      bus_data_in = IDLE_NIB;
      forever begin
         @(negedge clk_in);
         if (!reset_in && bus_sync === 1'b1 && (bus_data_out == 4'd2 || bus_data_out == 4'd4)) begin
            cnt = (bus_data_out == 4'd2) ? 1 : 8;
            repeat (RDL_P + 1) @(negedge clk_in);
            for (int n = 0; n < cnt; n++) begin
               bus_data_in = slv_word[31 - 4*n -: 4];
               @(negedge clk_in);
            end
            bus_data_in = IDLE_NIB;
         end
      end
   end

   always @(negedge clk_in) begin
      if (!reset_in && rsp_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_unexpected: rsp_valid with op %0d, required no response", rsp_op);
         end else begin
            sb_e = sbq.pop_front();
            chk("sb_op", 64'(rsp_op), 64'(sb_e.op));
            if (sb_e.op == 2'd3) chk("sb_iq", 64'({rsp_q, rsp_i}), 64'({sb_e.q, sb_e.i}));
            else if (sb_e.op == 2'd1) chk("sb_otr", 64'(rsp_otr), 64'(sb_e.otr));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      if (GAP_P < 1 || GAP_P > 15) $error("GAP_CYCLES %0d outside 1..15", GAP_P);
      if (RDL_P < 1 || RDL_P > 3)  $error("RD_LAT %0d outside 1..3", RDL_P);
   end

   initial begin
      //           op    freq       pa    tx    I         Q         slave ret      code  payload        nl fl eq        ei        otr
      tbl[0] = mk(2'd0, 22'h0977B7, 1'b1, 1'b0, 16'h0000, 16'h0000, 32'h0,         4'd1, 32'h40977B70, 7, 11, 16'h0,    16'h0,    1'b0);
      tbl[1] = mk(2'd2, 22'h0,      1'b0, 1'b0, 16'h8001, 16'h7FFE, 32'h0,         4'd3, 32'h7FFE8001, 8, 12, 16'h0,    16'h0,    1'b0);
      tbl[2] = mk(2'd3, 22'h0,      1'b0, 1'b0, 16'h0,    16'h0,    32'hA5C31234,  4'd4, 32'h0,        0, 13, 16'hA5C3, 16'h1234, 1'b0);
      tbl[3] = mk(2'd1, 22'h0,      1'b0, 1'b0, 16'h0,    16'h0,    32'h10000000,  4'd2, 32'h0,        0, 6,  16'h0,    16'h0,    1'b1);
      tbl[4] = mk(2'd1, 22'h0,      1'b0, 1'b0, 16'h0,    16'h0,    32'hE0000000,  4'd2, 32'h0,        0, 6,  16'h0,    16'h0,    1'b0);
      tbl[5] = mk(2'd0, 22'h3FFFFF, 1'b0, 1'b1, 16'h0,    16'h0,    32'h0,         4'd1, 32'h83FFFFF0, 7, 11, 16'h0,    16'h0,    1'b0);
      tbl[6] = mk(2'd2, 22'h0,      1'b0, 1'b0, 16'h0000, 16'hFFFF, 32'h0,         4'd3, 32'hFFFF0000, 8, 12, 16'h0,    16'h0,    1'b0);
      tbl[7] = mk(2'd3, 22'h0,      1'b0, 1'b0, 16'h0,    16'h0,    32'h80007FFF,  4'd4, 32'h0,        0, 13, 16'h8000, 16'h7FFF, 1'b0);
      tbl[8] = mk(2'd1, 22'h0,      1'b0, 1'b0, 16'h0,    16'h0,    32'hF0000000,  4'd2, 32'h0,        0, 6,  16'h0,    16'h0,    1'b1);
      tbl[9] = mk(2'd0, 22'h000000, 1'b1, 1'b1, 16'h0,    16'h0,    32'h0,         4'd1, 32'hC0000000, 7, 11, 16'h0,    16'h0,    1'b0);

      reset_in = 1'b1;
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_freq = '0; cmd_preamp = 1'b0; cmd_tx = 1'b0;
      cmd_tx_i = '0; cmd_tx_q = '0;
`ifdef OTR_STICKY_EN
      otr_clr = 1'b0;
      m_stk = 1'b0;
`endif
      repeat (3) @(negedge clk_in);
      chk("reset_state", 64'({bus_sync, bus_data_out, rsp_valid, busy, cmd_ready, rsp_q, rsp_i, rsp_otr}), 64'd0);
      reset_in = 1'b0;
      @(negedge clk_in);
      chk("ready_after_reset", 64'({cmd_ready, busy}), 64'b10);

      for (int i = 0; i < 10; i++) run_vec(tbl[i], i, 0);

      // Reset lands on the third payload nibble of a TX_IQ frame.
      run_vec(tbl[1], 100, 4);
      @(negedge clk_in);
      m_q = 16'h0; m_i = 16'h0; m_otr = 1'b0;
`ifdef OTR_STICKY_EN
      m_stk = 1'b0;
`endif
      chk("abort_outputs", 64'({bus_sync, bus_data_out, rsp_valid, busy, cmd_ready, rsp_q, rsp_i, rsp_otr}), 64'd0);
      reset_in = 1'b0;
      @(negedge clk_in);
      chk("abort_ready", 64'(cmd_ready), 64'd1);
      run_vec(tbl[2], 101, 0);

      // cmd_valid held high across three SET_PARAMS frames.
      wait_ready();
      cmd_valid = 1'b1; cmd_op = tbl[0].op; cmd_freq = tbl[0].freq;
      cmd_preamp = tbl[0].preamp; cmd_tx = tbl[0].tx;
      for (int f = 0; f < 3; f++) sbq.push_back('{2'd0, 16'h0, 16'h0, 1'b0});
      n_sync = 0;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk_in);
         if (bus_sync === 1'b1) begin
            if (n_sync < 3) sync_t[n_sync] = c;
            n_sync++;
         end
      end
      cmd_valid = 1'b0;
      chk("cont_sync_count", 64'(n_sync), 64'd3);
      chk("cont_first_sync", 64'(sync_t[0]), 64'd1);
      chk("cont_spacing1", 64'(sync_t[1] - sync_t[0]), 64'(11 + GAP_P - 1));
      chk("cont_spacing2", 64'(sync_t[2] - sync_t[1]), 64'(11 + GAP_P - 1));
      wait_ready();

`ifdef OTR_STICKY_EN
      run_vec(tbl[3], 200, 0);
      run_vec(tbl[4], 201, 0);
      @(negedge clk_in);
      otr_clr = 1'b1;
      @(negedge clk_in);
      otr_clr = 1'b0;
      m_stk = 1'b0;
      chk("sticky_cleared", 64'(otr_sticky), 64'(m_stk));
      otr_clr = 1'b1;
      run_vec(tbl[8], 202, 0);
      otr_clr = 1'b0;
`endif

      chk("sb_drained", 64'(sbq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
